// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared types, flag indices and helpers for the cpu core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_WAIT      = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_t;

  // Bit positions within the 4-bit {N,Z,C,V} flag vector.
  localparam int c_FLAG_N = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_C = 1;
  localparam int c_FLAG_V = 0;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    ror32 = 32'({v, v} >> n);
  endfunction

  function automatic logic cond_pass(input cond_t c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[c_FLAG_N];
    z  = f[c_FLAG_Z];
    cf = f[c_FLAG_C];
    v  = f[c_FLAG_V];
    case (c)
      CC_EQ:   cond_pass = z;
      CC_NE:   cond_pass = !z;
      CC_CS:   cond_pass = cf;
      CC_CC:   cond_pass = !cf;
      CC_MI:   cond_pass = n;
      CC_PL:   cond_pass = !n;
      CC_VS:   cond_pass = v;
      CC_VC:   cond_pass = !v;
      CC_HI:   cond_pass = cf && !z;
      CC_LS:   cond_pass = !cf || z;
      CC_GE:   cond_pass = (n == v);
      CC_LT:   cond_pass = (n != v);
      CC_GT:   cond_pass = !z && (n == v);
      CC_LE:   cond_pass = z || (n != v);
      CC_AL:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
//  Module   : cpu_alu
//  Brief    : Data-processing ALU: result and N,Z,C,V from Rn and operand2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] i_rn,
  input  logic [31:0] i_op2,
  input  logic        i_sh_c,
  input  opcode_t     i_opcode,
  input  logic        i_c,
  input  logic        i_v,
  output logic [31:0] o_result,
  output logic        o_n,
  output logic        o_z,
  output logic        o_c,
  output logic        o_v
);

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_cin;
  logic        w_arith;
  logic [32:0] w_sum;

  always_comb begin
    w_a      = i_rn;
    w_b      = i_op2;
    w_cin    = 1'b0;
    w_arith  = 1'b0;
    o_result = 32'd0;
    case (i_opcode)
      OP_AND, OP_TST: o_result = i_rn & i_op2;
      OP_EOR, OP_TEQ: o_result = i_rn ^ i_op2;
      OP_ORR:         o_result = i_rn | i_op2;
      OP_MOV:         o_result = i_op2;
      OP_BIC:         o_result = i_rn & ~i_op2;
      OP_MVN:         o_result = ~i_op2;
      OP_SUB, OP_CMP: begin w_arith = 1'b1; w_b = ~i_op2; w_cin = 1'b1; end
      OP_RSB:         begin w_arith = 1'b1; w_a = i_op2; w_b = ~i_rn; w_cin = 1'b1; end
      OP_ADD, OP_CMN: begin w_arith = 1'b1; end
      OP_ADC:         begin w_arith = 1'b1; w_cin = i_c; end
      OP_SBC:         begin w_arith = 1'b1; w_b = ~i_op2; w_cin = i_c; end
      OP_RSC:         begin w_arith = 1'b1; w_a = i_op2; w_b = ~i_rn; w_cin = i_c; end
      default:        o_result = 32'd0;
    endcase
    // Subtraction is a + ~b + 1, so the carry out is already NOT borrow.
    w_sum = {1'b0, w_a} + {1'b0, w_b} + {32'd0, w_cin};
    o_c   = i_sh_c;
    o_v   = i_v;
    if (w_arith) begin
      o_result = w_sum[31:0];
      o_c      = w_sum[32];
      o_v      = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
    end
    o_n = o_result[31];
    o_z = (o_result == 32'd0);
  end

endmodule

`default_nettype wire

// File: rtl/cpu.sv
// ============================================================================
//  Module   : cpu
//  Brief    : Single-instruction ARM-style data-processing core, one
//             instruction per reset. COND_EXEC_EN enables condition codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        waiting,
  output logic [31:0] status_out,
  output logic [31:0] datapath_out
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_regs [16];
  logic [31:0] r_rn_val;
  logic [31:0] r_op2;
  logic        r_sh_c;
  logic [31:0] r_dp_out;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic [3:0]  r_new_flags;
  logic        r_do_wb;
  logic        r_do_flags;

  logic [31:0] w_rm;
  logic [4:0]  w_amt;
  logic [32:0] w_t;
  logic [31:0] w_sh_val;
  logic        w_sh_c;
  logic [31:0] w_alu_res;
  logic        w_n, w_z, w_c, w_v;
  logic        w_is_dp;
  logic        w_is_test;
  logic        w_cond_ok;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     w_next = S_DECODE;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  // Operand2 barrel shifter; a zero shift or rotate keeps the current C.
  always_comb begin
    w_rm     = r_regs[r_ir[3:0]];
    w_amt    = r_ir[4] ? 5'd0 : r_ir[11:7];
    w_t      = 33'd0;
    w_sh_val = w_rm;
    w_sh_c   = r_flags[c_FLAG_C];
    if (r_ir[25]) begin
      w_sh_val = ror32({24'd0, r_ir[7:0]}, {r_ir[11:8], 1'b0});
      if (r_ir[11:8] != 4'd0) w_sh_c = w_sh_val[31];
    end else if (w_amt != 5'd0) begin
      case (shift_t'(r_ir[6:5]))
        SH_LSL: begin
          w_t      = {1'b0, w_rm} << w_amt;
          w_sh_val = w_t[31:0];
          w_sh_c   = w_t[32];
        end
        SH_LSR: begin
          w_t      = {w_rm, 1'b0} >> w_amt;
          w_sh_val = w_t[32:1];
          w_sh_c   = w_t[0];
        end
        SH_ASR: begin
          w_t      = 33'($signed({w_rm, 1'b0}) >>> w_amt);
          w_sh_val = w_t[32:1];
          w_sh_c   = w_t[0];
        end
        default: begin
          w_sh_val = ror32(w_rm, w_amt);
          w_sh_c   = w_sh_val[31];
        end
      endcase
    end
  end

  cpu_alu u_alu (
    .i_rn     (r_rn_val),
    .i_op2    (r_op2),
    .i_sh_c   (r_sh_c),
    .i_opcode (opcode_t'(r_ir[24:21])),
    .i_c      (r_flags[c_FLAG_C]),
    .i_v      (r_flags[c_FLAG_V]),
    .o_result (w_alu_res),
    .o_n      (w_n),
    .o_z      (w_z),
    .o_c      (w_c),
    .o_v      (w_v)
  );

  assign w_is_dp   = (r_ir[27:26] == 2'b00);
  assign w_is_test = (r_ir[24:23] == 2'b10);

`ifdef COND_EXEC_EN
  assign w_cond_ok = cond_pass(cond_t'(r_ir[31:28]), r_flags);
`else
  logic [3:0] w_unused_cond;
  assign w_unused_cond = r_ir[31:28];
  assign w_cond_ok     = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ir        <= 32'd0;
      r_rn_val    <= 32'd0;
      r_op2       <= 32'd0;
      r_sh_c      <= 1'b0;
      r_dp_out    <= 32'd0;
      r_result    <= 32'd0;
      r_flags     <= 4'd0;
      r_new_flags <= 4'd0;
      r_do_wb     <= 1'b0;
      r_do_flags  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_ir <= instr;
        S_DECODE: begin
          r_rn_val <= r_regs[r_ir[19:16]];
          r_op2    <= w_sh_val;
          r_sh_c   <= w_sh_c;
        end
        S_EXECUTE: begin
          r_do_wb    <= w_is_dp && w_cond_ok && !w_is_test;
          r_do_flags <= w_is_dp && w_cond_ok && (r_ir[20] || w_is_test);
          if (w_is_dp) begin
            r_dp_out    <= w_alu_res;
            r_result    <= w_alu_res;
            r_new_flags <= {w_n, w_z, w_c, w_v};
          end
        end
        S_WRITEBACK: if (r_do_flags) r_flags <= r_new_flags;
        default: ;
      endcase
    end
  end

  // The register file deliberately survives reset; a held reset blocks writes.
  always_ff @(posedge clk) begin
    if (!rst_n && (r_state == S_WRITEBACK) && r_do_wb)
      r_regs[r_ir[15:12]] <= r_result;
  end

  assign waiting      = (r_state == S_WAIT);
  assign status_out   = {r_flags, 28'd0};
  assign datapath_out = r_dp_out;

endmodule

`default_nettype wire

// File: tb/tb_cpu.sv
// ============================================================================
//  Module   : tb_cpu
//  Brief    : Directed self-checking bench for the cpu core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        waiting;
  logic [31:0] status_out;
  logic [31:0] datapath_out;

  int n_cmp = 0;
  int n_err = 0;

  cpu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .waiting      (waiting),
    .status_out   (status_out),
    .datapath_out (datapath_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse reset, present w, scramble instr after FETCH, run 4 edges total.
  task automatic run(input logic [31:0] w);
    rst_n = 1'b1;
    instr = w;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 instr = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_chk(input string tag, input logic [31:0] w,
                         input logic [31:0] exp_dp, input logic [31:0] exp_st);
    run(w);
    chk({tag, "_dp"}, datapath_out, exp_dp);
    chk({tag, "_st"}, status_out, exp_st);
    chk({tag, "_wait"}, {31'd0, waiting}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    instr = 32'd0;
    #1;
    chk("reset_dp", datapath_out, 32'd0);
    chk("reset_st", status_out, 32'd0);
    chk("reset_wait", {31'd0, waiting}, 32'd0);

    // First round checked edge by edge: waiting must stay low until edge 4.
    @(negedge clk);
    instr = 32'hE3A0_0001;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mov0_wait_edge3", {31'd0, waiting}, 32'd0);
    @(posedge clk);
    #1;
    chk("mov0_dp", datapath_out, 32'd1);
    chk("mov0_st", status_out, 32'd0);
    chk("mov0_wait", {31'd0, waiting}, 32'd1);

    for (int k = 1; k < 16; k++) begin
      run(32'hE3A0_0000 | (k << 12) | (k + 1));
      chk("movk_dp", datapath_out, 32'(k + 1));
    end

    // Condition EQ fails under COND_EXEC_EN but datapath_out still updates.
    run_chk("adds_r0", 32'h0090_0000, 32'd2, 32'd0);
    run_chk("subs_r2", 32'hE051_2001, 32'd0, 32'h6000_0000);
    run_chk("mov_r9_r2", 32'hE1A0_9002, 32'd0, 32'd0);
    run_chk("mov_r3_ror", 32'hE3A0_34FF, 32'hFF00_0000, 32'd0);
    run_chk("cmp_r3_0", 32'hE353_0000, 32'hFF00_0000, 32'hA000_0000);
    run_chk("cmp_r3_1", 32'hE353_0001, 32'hFEFF_FFFF, 32'hA000_0000);
    run_chk("mov_r10_r3", 32'hE1A0_A003, 32'hFF00_0000, 32'd0);
    run_chk("movs_lsr", 32'hE1B0_E121, 32'd0, 32'h6000_0000);
    run_chk("adds_r15", 32'hE093_F003, 32'hFE00_0000, 32'hA000_0000);

    run_chk("moveq_r4", 32'h03A0_4007, 32'd7, 32'd0);
`ifdef COND_EXEC_EN
    run_chk("mov_r11_r4", 32'hE1A0_B004, 32'd5, 32'd0);
`else
    run_chk("mov_r11_r4", 32'hE1A0_B004, 32'd7, 32'd0);
`endif

    // Non data-processing encoding: no result, no flags, no writeback.
    run_chk("nondp", 32'hE590_1000, 32'd0, 32'd0);
    run_chk("mov_r13_r1", 32'hE1A0_D001, 32'd2, 32'd0);

    // Reset asserted while MOV R5,#9 sits in EXECUTE.
    run_chk("pre_abort", 32'hE3A0_6011, 32'h11, 32'd0);
    instr = 32'hE3A0_5009;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("abort_dp", datapath_out, 32'd0);
    chk("abort_wait", {31'd0, waiting}, 32'd0);
    chk("abort_st", status_out, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("abort_hold_dp", datapath_out, 32'd0);
    run_chk("mov_r12_r5", 32'hE1A0_C005, 32'd6, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
